multicycle_main_control: RTL and testbench
==========================================

# multicycle_main_control

Moore-style main control FSM for the multicycle MIPS datapath. It decodes the 6-bit instruction opcode and steps through the fetch, decode, execute, memory and write-back phases, one state per cycle. In each state it drives the datapath enables and multiplexer selects. It also supplies `ALUOp1`/`ALUOp0` to the ALU control unit directly downstream, which combines them with the funct field to select the ALU operation. Memory accesses stall on a `mem_ready` handshake.

## Interface
Parameters:
- `OP_RTYPE`, default 6'b000000, R-format opcode
- `OP_LW`, default 6'b100011, load word
- `OP_SW`, default 6'b101011, store word
- `OP_BEQ`, default 6'b000100, branch on equal
- `OP_J`, default 6'b000010, jump

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock; rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  Instr[31:26] from the instruction register; sampled in DECODE
- `mem_ready`  in  1  memory has completed the current read/write this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  datapath controls
- `ALUSrcB`  out  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 shifted imm
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `ALUOp1`, `ALUOp0`  out  1 each  to ALU control: 00 add, 01 subtract, 10 use funct
- `illegal_op`  out  1  opcode not recognised (DECODE only)
- `state`  out  4  current state encoding, for debug

## Operation
States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BRANCH=8, JUMP=9, RESET=10.

Outputs are 0 unless they are listed for the state.

- **RESET:** all outputs 0. Next state is FETCH.
- **FETCH:** MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Stay in FETCH while !mem_ready, otherwise go to DECODE.
- **DECODE:** ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode: lw/sw go to MEMADR, R-type to EXEC, beq to BRANCH, j to JUMP. Any other opcode: illegal_op=1 and next state is FETCH (the instruction executes as a no-op; PC has already advanced).
- **MEMADR:** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD for lw, MEMWR for sw. The opcode is held stable by the IR.
- **MEMRD:** MemRead=1, IorD=1. Stay while !mem_ready, otherwise go to MEMWB.
- **MEMWB:** RegWrite=1, MemtoReg=1, RegDst=0. Next state is FETCH.
- **MEMWR:** MemWrite=1, IorD=1. Stay while !mem_ready, otherwise go to FETCH.
- **EXEC:** ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state is RCOMP.
- **RCOMP:** RegWrite=1, RegDst=1, MemtoReg=0. Next state is FETCH.
- **BRANCH:** ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state is FETCH.
- **JUMP:** PCWrite=1, PCSource=10. Next state is FETCH.

Implementation rules:
- The `state` register is the only storage element.
- Every output is decoded from `state`. `mem_ready` feeds only IRWrite/PCWrite in FETCH and the wait transitions.

## Timing
- `rst` sampled high at a rising edge forces state to RESET, regardless of the current state. This includes the memory wait states, so a pending access is abandoned.
- After reset: every output is 0 and `state`=10, for as long as `rst` stays high and for the first cycle after it is released. FETCH is entered on the following edge.
- Cycles per instruction with `mem_ready` tied high: lw 5, sw 4, R-type 4, beq 3, j 3, illegal opcode 2.
- Each cycle with `mem_ready` low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- IRWrite and PCWrite pulse for exactly one cycle per fetch: the cycle in which `mem_ready` is 1.
- `ALUOp1`/`ALUOp0` are valid in the same cycle as `state`. The ALU control unit is combinational, so the ALU operation is valid within that cycle.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - state encodings, as 4-bit localparams;
  - opcode constants;
  - ALUOp codes (ADD=2'b00, SUB=2'b01, FUNCT=2'b10);
  - ALUSrcB and PCSource select codes.
- One sub-module is natural: `mc_next_state`, a combinational next-state function of (`state`, `opcode`, `mem_ready`). The top level holds the state register and the output decode.

## Test plan
- Reset: `rst`=1 for 3 cycles → every output 0, `state`=10. The first cycle after release still shows `state`=10; the next shows `state`=0 with MemRead=1, ALUSrcB=01.
- R-type add (opcode 000000), `mem_ready`=1 → state sequence 0,1,6,7,0. In state 6: ALUOp1=1, ALUOp0=0. In state 7: RegWrite=1, RegDst=1.
- lw (100011), with `mem_ready` low for 2 cycles in MEMRD → sequence 0,1,2,3,3,3,4,0. MemRead=1 and IorD=1 in all three MEMRD cycles. MemtoReg=1 in state 4.
- beq (000100) → sequence 0,1,8,0. In state 8: ALUOp=01, PCWriteCond=1, PCSource=01. j (000010) → sequence 0,1,9,0 with PCWrite=1, PCSource=10.
- Illegal opcode 111111 → illegal_op=1 for the single DECODE cycle, then `state` returns to 0.
- `rst` asserted while in MEMWR with `mem_ready`=0 → next state 10 and MemWrite drops to 0 on that edge.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main control: state encodings,
// opcodes, ALUOp codes and datapath mux select codes.
package mc_ctrl_pkg;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_RCOMP  = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_JUMP   = 4'd9;
  localparam logic [3:0] ST_RESET  = 4'd10;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state function of the multicycle main control FSM;
// also reports whether the opcode is one the FSM knows how to execute.
module mc_next_state
  import mc_ctrl_pkg::*;
#(
  parameter logic [5:0] OP_RTYPE = OPC_RTYPE,
  parameter logic [5:0] OP_LW    = OPC_LW,
  parameter logic [5:0] OP_SW    = OPC_SW,
  parameter logic [5:0] OP_BEQ   = OPC_BEQ,
  parameter logic [5:0] OP_J     = OPC_J
) (
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [3:0] next_state,
  output logic       op_known
);

  assign op_known = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ)   || (opcode == OP_J);

  // NOTE: every combinational output gets a default before the case, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = ST_RESET;
    case (state)
      ST_RESET:  next_state = ST_FETCH;
      ST_FETCH:  next_state = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) next_state = ST_MEMADR;
        else if (opcode == OP_RTYPE)            next_state = ST_EXEC;
        else if (opcode == OP_BEQ)              next_state = ST_BRANCH;
        else if (opcode == OP_J)                next_state = ST_JUMP;
        else                                    next_state = ST_FETCH;
      end
      // The IR holds the opcode, so MEMADR can re-decode lw vs sw.
      ST_MEMADR: next_state = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  next_state = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  next_state = ST_FETCH;
      ST_MEMWR:  next_state = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   next_state = ST_RCOMP;
      ST_RCOMP:  next_state = ST_FETCH;
      ST_BRANCH: next_state = ST_FETCH;
      ST_JUMP:   next_state = ST_FETCH;
      default:   next_state = ST_RESET;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Moore-style main control FSM for the multicycle MIPS datapath: holds the
// state register and decodes all datapath controls from the current state.
module multicycle_main_control
  import mc_ctrl_pkg::*;
#(
  parameter logic [5:0] OP_RTYPE = OPC_RTYPE,
  parameter logic [5:0] OP_LW    = OPC_LW,
  parameter logic [5:0] OP_SW    = OPC_SW,
  parameter logic [5:0] OP_BEQ   = OPC_BEQ,
  parameter logic [5:0] OP_J     = OPC_J
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       ALUOp1,
  output logic       ALUOp0,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] next_state;
  logic       op_known;
  logic [1:0] aluop;

  mc_next_state #(
    .OP_RTYPE (OP_RTYPE),
    .OP_LW    (OP_LW),
    .OP_SW    (OP_SW),
    .OP_BEQ   (OP_BEQ),
    .OP_J     (OP_J)
  ) u_next_state (
    .state      (state),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .next_state (next_state),
    .op_known   (op_known)
  );

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RESET;
    else     state <= next_state;
  end

  assign {ALUOp1, ALUOp0} = aluop;

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcB     = SRCB_REG;
    PCSource    = PCSRC_ALU;
    aluop       = ALUOP_ADD;
    illegal_op  = 1'b0;
    case (state)
      ST_FETCH: begin
        // IR and PC capture only in the cycle the fetched word is delivered.
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      ST_DECODE: begin
        ALUSrcB    = SRCB_SHIMM;
        illegal_op = !op_known;
      end
      ST_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ST_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      ST_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      ST_EXEC: begin
        ALUSrcA = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ST_RCOMP: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        aluop       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: directed per-cycle vectors
// queue expected state/outputs; a negedge monitor compares them.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b000000;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       ALUSrcA, RegWrite, RegDst, ALUOp1, ALUOp0, illegal_op;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_main_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .illegal_op(illegal_op), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst;
    logic [1:0] srcb, pcsrc, aluop;
    logic ill;
  } obs_t;

  typedef struct {
    logic       rst;
    logic       mr;
    logic [5:0] op;
    logic [3:0] st;
  } vec_t;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, BAD = 6'b111111;

  vec_t vecs[$];
  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  // Expected controls from the per-state output table, written out by hand.
  function automatic obs_t expect_obs(input logic [3:0] st, input logic mr, input logic [5:0] op);
    obs_t e;
    e = '0;
    e.st = st;
    case (st)
      4'd0: begin e.mrd = 1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
      4'd1: begin
        e.srcb = 2'b11;
        e.ill = !(op == R || op == LW || op == SW || op == BEQ || op == J);
      end
      4'd2: begin e.srca = 1; e.srcb = 2'b10; end
      4'd3: begin e.mrd = 1; e.iord = 1; end
      4'd4: begin e.rw = 1; e.m2r = 1; end
      4'd5: begin e.mwr = 1; e.iord = 1; end
      4'd6: begin e.srca = 1; e.aluop = 2'b10; end
      4'd7: begin e.rw = 1; e.rdst = 1; end
      4'd8: begin e.srca = 1; e.aluop = 2'b01; e.pcwc = 1; e.pcsrc = 2'b01; end
      4'd9: begin e.pcw = 1; e.pcsrc = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic add(input logic r, input logic mr, input logic [5:0] op, input logic [3:0] st);
    vec_t v;
    v.rst = r; v.mr = mr; v.op = op; v.st = st;
    vecs.push_back(v);
  endtask

  // Each vector: inputs driven during a cycle and the state expected in it.
  initial begin
    add(1, 1, R, 10); add(1, 1, R, 10); add(1, 1, R, 10); add(0, 1, R, 10);
    // R-type: 0,1,6,7
    add(0, 1, R, 0); add(0, 1, R, 1); add(0, 1, R, 6); add(0, 1, R, 7);
    // lw with two stall cycles in MEMRD: 0,1,2,3,3,3,4
    add(0, 1, LW, 0); add(0, 1, LW, 1); add(0, 1, LW, 2);
    add(0, 0, LW, 3); add(0, 0, LW, 3); add(0, 1, LW, 3); add(0, 1, LW, 4);
    // beq: 0,1,8 ; j: 0,1,9 ; illegal: 0,1
    add(0, 1, BEQ, 0); add(0, 1, BEQ, 1); add(0, 1, BEQ, 8);
    add(0, 1, J, 0);   add(0, 1, J, 1);   add(0, 1, J, 9);
    add(0, 1, BAD, 0); add(0, 1, BAD, 1);
    // sw with one fetch stall: 0,0,1,2,5
    add(0, 0, SW, 0); add(0, 1, SW, 0); add(0, 1, SW, 1); add(0, 1, SW, 2); add(0, 1, SW, 5);
    // sw stalled in MEMWR, reset mid-access: 0,1,2,5,5,10,0
    add(0, 1, SW, 0); add(0, 1, SW, 1); add(0, 1, SW, 2);
    add(0, 0, SW, 5); add(1, 0, SW, 5); add(0, 1, SW, 10); add(0, 1, SW, 0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst       = vecs[i].rst;
      mem_ready = vecs[i].mr;
      opcode    = vecs[i].op;
      exp_q.push_back(expect_obs(vecs[i].st, vecs[i].mr, vecs[i].op));
    end
    @(posedge clk);
    stim_done = 1'b1;
  end

  initial begin
    obs_t act, e;
    bit   finished = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act = '{state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                ALUSrcA, RegWrite, RegDst, ALUSrcB, PCSource, {ALUOp1, ALUOp0}, illegal_op};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL cyc%0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                   checks, act.st, act[18:0], e.st, e[18:0]);
        end
      end
      if (stim_done && exp_q.size() == 0) finished = 1'b1;
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL timeout: stimulus not drained, %0d entries left", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
